regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (WR/WD/RW) between two writeback
//  requesters: ALU result path (A) and memory-load path (M).
//  Each requester has a small FIFO with a valid/ready handshake.
//  A round-robin arbiter drains one entry per cycle onto registered write-port outputs.
//  Sits between the execute/memory stages and the Registers block.
// PARAMETERS
//  DATA_W  32  write data width (bit 0 = MSB, ascending [0:DATA_W-1] like the register file)
//  ADDR_W  5   register address width ([0:ADDR_W-1])
//  DEPTH   2   entries per requester FIFO; power of 2, >=2
// PORTS
//  clk       in   1       system clock, rising edge
//  rst_n     in   1       asynchronous active-low reset
//  a_valid   in   1       ALU writeback request valid
//  a_ready   out  1       ALU FIFO can accept (= !a_full)
//  a_addr    in   ADDR_W  ALU destination register
//  a_data    in   DATA_W  ALU result
//  m_valid   in   1       load writeback request valid
//  m_ready   out  1       load FIFO can accept (= !m_full)
//  m_addr    in   ADDR_W  load destination register
//  m_data    in   DATA_W  load data
//  rf_we     out  1       to register file RW
//  rf_wr     out  ADDR_W  to register file WR
//  rf_wd     out  DATA_W  to register file WD
//  busy      out  1       any FIFO non-empty OR rf_we
// BEHAVIOUR
//  - Reset: both FIFOs empty, a_ready=m_ready=1, rf_we=0, rf_wr=0, rf_wd=0, busy=0, rr_last=M.
//  - Push: on a rising edge with x_valid && x_ready. Ready depends only on full.
//    A full FIFO rejects a push even when it is popped in the same cycle.
//    No combinational valid->ready path.
//  - Push and pop in the same cycle on a non-full FIFO: both happen; count unchanged.
//  - Arbitration, evaluated each cycle from the FIFO heads:
//    - Only one FIFO non-empty -> grant it.
//    - Both non-empty -> grant the requester opposite rr_last; rr_last <= granted.
//    - Neither non-empty -> no grant, rr_last held.
//  - Pop: the granted head is popped at the edge.
//    rf_we/rf_wr/rf_wd are registered from the popped entry and valid for exactly one cycle.
//    Next cycle rf_we=0 unless another entry is popped.
//    rf_wr/rf_wd hold their last value when rf_we=0.
//  - Register 0: an entry with addr==0 is popped and consumes its grant, but rf_we stays 0.
//  - Latency: entry pushed at edge k -> popped at edge k+1 at the earliest -> rf_we high in cycle k+1..k+2.
//  - Throughput: 1 write/cycle total; each FIFO sustains 1/cycle when uncontended,
//    1 per 2 cycles when both are continuously busy.
//  - Ordering: FIFO order within a requester.
//    Cross-requester order follows grant order only; WAW hazards across paths are the hazard unit's job.
//  - FIFO pointers: ADDR log2(DEPTH) bits plus a wrap bit.
//    full = same index, different wrap bit; empty = equal pointers.
//  - Reset asserted mid-operation: pending entries discarded; an in-flight rf_we drops to 0 asynchronously.
// CONFIGURATION
//  RF_FWD_EN defined:
//    - Adds ports rd_addr1/rd_addr2 (in, ADDR_W), fwd_hit1/fwd_hit2 (out, 1),
//      fwd_data1/fwd_data2 (out, DATA_W).
//    - fwd_hitN = rf_we && rf_wr==rd_addrN && rd_addrN!=0, combinational.
//    - fwd_dataN = rf_wd when hit, else 0.
//    - Lets the decode stage bypass the write in flight this cycle.
//  RF_FWD_EN undefined: those ports and that logic are absent; all other behaviour identical.
// TESTING
//  - Reset:
//    - Stimulus: hold rst_n=0 with a_valid=m_valid=1.
//    - Required: a_ready=m_ready=1, rf_we=0, busy=0; no push is recorded after release.
//  - Single A write:
//    - Stimulus: a_addr=5, a_data=32'h0000_1234 pushed at edge 1.
//    - Required: rf_we=1, rf_wr=5, rf_wd=32'h1234 for exactly the cycle after edge 2; busy=0 after.
//  - Contention:
//    - Stimulus: A pushes (3,0xA) and M pushes (4,0xB) on the same edge after reset.
//    - Required: A write (3,0xA) first, then M write (4,0xB) on the next cycle.
//  - Full/backpressure:
//    - Stimulus: M held valid for 4 cycles while A keeps a continuous stream, DEPTH=2.
//    - Required: m_ready drops once M holds 2 entries; grants alternate A/M;
//      no entry is lost or duplicated.
//  - Register 0:
//    - Stimulus: push (0,0xFFFF_FFFF), then (7,0x1).
//    - Required: rf_we stays 0 for the first entry; rf_we=1 with rf_wr=7 on the following cycle.
//  - RF_FWD_EN:
//    - Stimulus: rd_addr1=9 while the (9,0x55) write is on the port.
//    - Required: fwd_hit1=1, fwd_data1=0x55; with rd_addr1=0, fwd_hit1=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester writeback arbiter for the register-file write port (optional macro RF_FWD_EN)
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [0:ADDR_W-1] a_addr,
    input  logic [0:DATA_W-1] a_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [0:ADDR_W-1] m_addr,
    input  logic [0:DATA_W-1] m_data,
    output logic              rf_we,
    output logic [0:ADDR_W-1] rf_wr,
    output logic [0:DATA_W-1] rf_wd,
    output logic              busy
`ifdef RF_FWD_EN
    ,
    input  logic [0:ADDR_W-1] rd_addr1,
    input  logic [0:ADDR_W-1] rd_addr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [0:DATA_W-1] fwd_data1,
    output logic [0:DATA_W-1] fwd_data2
`endif
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        RR_A = 1'b0,
        RR_M = 1'b1
    } rr_e;

    logic [0:ADDR_W-1] a_mem_addr_q [DEPTH];
    logic [0:DATA_W-1] a_mem_data_q [DEPTH];
    logic [0:ADDR_W-1] m_mem_addr_q [DEPTH];
    logic [0:DATA_W-1] m_mem_data_q [DEPTH];

    logic [PW:0] a_wp_q, a_wp_d, a_rp_q, a_rp_d;
    logic [PW:0] m_wp_q, m_wp_d, m_rp_q, m_rp_d;
    rr_e         rr_q, rr_d;

    logic              rf_we_q, rf_we_d;
    logic [0:ADDR_W-1] rf_wr_q, rf_wr_d;
    logic [0:DATA_W-1] rf_wd_q, rf_wd_d;

    logic a_full, a_empty, m_full, m_empty;
    logic a_push, m_push, grant_a, grant_m;
    logic [0:ADDR_W-1] pop_addr;
    logic [0:DATA_W-1] pop_data;

    // Full when indices match but wrap bits differ; empty when pointers are equal.
    assign a_full  = (a_wp_q[PW-1:0] == a_rp_q[PW-1:0]) && (a_wp_q[PW] != a_rp_q[PW]);
    assign m_full  = (m_wp_q[PW-1:0] == m_rp_q[PW-1:0]) && (m_wp_q[PW] != m_rp_q[PW]);
    assign a_empty = (a_wp_q == a_rp_q);
    assign m_empty = (m_wp_q == m_rp_q);

    // Ready comes from registered state only, so a full FIFO refuses even when popped.
    assign a_ready = !a_full;
    assign m_ready = !m_full;
    assign a_push  = a_valid && !a_full;
    assign m_push  = m_valid && !m_full;

    // Round-robin grant, pointer advance and next write-port values.
    always_comb begin
        grant_a  = 1'b0;
        grant_m  = 1'b0;
        rr_d     = rr_q;
        pop_addr = a_mem_addr_q[a_rp_q[PW-1:0]];
        pop_data = a_mem_data_q[a_rp_q[PW-1:0]];
        if (!a_empty && !m_empty) begin
            if (rr_q == RR_M) begin
                grant_a = 1'b1;
                rr_d    = RR_A;
            end else begin
                grant_m = 1'b1;
                rr_d    = RR_M;
            end
        end else if (!a_empty) begin
            grant_a = 1'b1;
        end else if (!m_empty) begin
            grant_m = 1'b1;
        end
        if (grant_m) begin
            pop_addr = m_mem_addr_q[m_rp_q[PW-1:0]];
            pop_data = m_mem_data_q[m_rp_q[PW-1:0]];
        end
        a_wp_d = a_wp_q + (PW+1)'(a_push);
        m_wp_d = m_wp_q + (PW+1)'(m_push);
        a_rp_d = a_rp_q + (PW+1)'(grant_a);
        m_rp_d = m_rp_q + (PW+1)'(grant_m);
        // Writes to register 0 consume the grant but never reach the port.
        rf_we_d = (grant_a || grant_m) && (pop_addr != '0);
        rf_wr_d = rf_we_d ? pop_addr : rf_wr_q;
        rf_wd_d = rf_we_d ? pop_data : rf_wd_q;
    end

    // FIFO payload storage; contents need no reset because pointers gate them.
    always_ff @(posedge clk) begin
        if (a_push) begin
            a_mem_addr_q[a_wp_q[PW-1:0]] <= a_addr;
            a_mem_data_q[a_wp_q[PW-1:0]] <= a_data;
        end
        if (m_push) begin
            m_mem_addr_q[m_wp_q[PW-1:0]] <= m_addr;
            m_mem_data_q[m_wp_q[PW-1:0]] <= m_data;
        end
    end

    // Control state and registered write port; reset discards all pending entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wp_q  <= '0;
            a_rp_q  <= '0;
            m_wp_q  <= '0;
            m_rp_q  <= '0;
            rr_q    <= RR_M;
            rf_we_q <= 1'b0;
            rf_wr_q <= '0;
            rf_wd_q <= '0;
        end else begin
            a_wp_q  <= a_wp_d;
            a_rp_q  <= a_rp_d;
            m_wp_q  <= m_wp_d;
            m_rp_q  <= m_rp_d;
            rr_q    <= rr_d;
            rf_we_q <= rf_we_d;
            rf_wr_q <= rf_wr_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wr = rf_wr_q;
    assign rf_wd = rf_wd_q;
    assign busy  = !a_empty || !m_empty || rf_we_q;

`ifdef RF_FWD_EN
    // Bypass the write currently on the port to the decode-stage read addresses.
    assign fwd_hit1  = rf_we_q && (rf_wr_q == rd_addr1) && (rd_addr1 != '0);
    assign fwd_hit2  = rf_we_q && (rf_wr_q == rd_addr2) && (rd_addr2 != '0);
    assign fwd_data1 = fwd_hit1 ? rf_wd_q : '0;
    assign fwd_data2 = fwd_hit2 ? rf_wd_q : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, m_valid;
    logic        a_ready, m_ready;
    logic [0:4]  a_addr, m_addr;
    logic [0:31] a_data, m_data;
    logic        rf_we;
    logic [0:4]  rf_wr;
    logic [0:31] rf_wd;
    logic        busy;
`ifdef RF_FWD_EN
    logic [0:4]  rd_addr1, rd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [0:31] fwd_data1, fwd_data2;
`endif

    int total;
    int bad;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .rf_we    (rf_we),
        .rf_wr    (rf_wr),
        .rf_wd    (rf_wd),
        .busy     (busy)
`ifdef RF_FWD_EN
        ,
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .fwd_hit1 (fwd_hit1),
        .fwd_hit2 (fwd_hit2),
        .fwd_data1(fwd_data1),
        .fwd_data2(fwd_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n   = 1'b0;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        m_valid = 1'b1; m_addr = 5'd2; m_data = 32'h22;
        repeat (3) step();
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_a_ready got=%0b want=1", a_ready); end
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL reset_m_ready got=%0b want=1", m_ready); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0b want=0", rf_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (rf_wr !== 5'd0 || rf_wd !== 32'd0) begin bad++; $display("FAIL reset_port got=%0h/%0h want=0/0", rf_wr, rf_wd); end
        a_valid = 1'b0; m_valid = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        total++; if (busy !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL reset_no_push busy=%0b we=%0b want=0/0", busy, rf_we); end
    endtask

    task automatic test_single_a();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_1234;
        step();
        a_valid = 1'b0;
        total++; if (rf_we !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_after_push we=%0b busy=%0b want=0/1", rf_we, busy); end
        step();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%0b want=1", rf_we); end
        total++; if (rf_wr !== 5'd5) begin bad++; $display("FAIL single_wr got=%0d want=5", rf_wr); end
        total++; if (rf_wd !== 32'h1234) begin bad++; $display("FAIL single_wd got=%0h want=1234", rf_wd); end
        step();
        total++; if (rf_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_after we=%0b busy=%0b want=0/0", rf_we, busy); end
        total++; if (rf_wr !== 5'd5 || rf_wd !== 32'h1234) begin bad++; $display("FAIL single_hold got=%0d/%0h want=5/1234", rf_wr, rf_wd); end
    endtask

    task automatic test_contention();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA;
        m_valid = 1'b1; m_addr = 5'd4; m_data = 32'hB;
        step();
        a_valid = 1'b0; m_valid = 1'b0;
        step();
        total++; if (rf_we !== 1'b1 || rf_wr !== 5'd3 || rf_wd !== 32'hA) begin bad++; $display("FAIL contention_first got=%0b/%0d/%0h want=1/3/a", rf_we, rf_wr, rf_wd); end
        step();
        total++; if (rf_we !== 1'b1 || rf_wr !== 5'd4 || rf_wd !== 32'hB) begin bad++; $display("FAIL contention_second got=%0b/%0d/%0h want=1/4/b", rf_we, rf_wr, rf_wd); end
        step();
        total++; if (rf_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL contention_idle we=%0b busy=%0b want=0/0", rf_we, busy); end
    endtask

    task automatic test_backpressure();
        logic [0:4]  qa_addr[$];
        logic [0:31] qa_data[$];
        logic [0:4]  qm_addr[$];
        logic [0:31] qm_data[$];
        int          src[$];
        int          ai = 0;
        int          mj = 0;
        int          writes = 0;
        int          last_m = -1;
        int          alt_errs = 0;
        logic        seen_mfull = 1'b0;
        logic        acc_a, acc_m, is_m;
        logic [0:4]  ea;
        logic [0:31] ed;
        for (int c = 0; c < 40; c++) begin
            a_valid = (c < 8); a_addr = 5'(8 + ai);  a_data = 32'h100 + 32'(ai);
            m_valid = (c < 4); m_addr = 5'(16 + mj); m_data = 32'h200 + 32'(mj);
            if (m_valid && !m_ready) seen_mfull = 1'b1;
            acc_a = a_valid && a_ready;
            acc_m = m_valid && m_ready;
            if (acc_a) begin qa_addr.push_back(a_addr); qa_data.push_back(a_data); end
            if (acc_m) begin qm_addr.push_back(m_addr); qm_data.push_back(m_data); end
            step();
            if (acc_a) ai++;
            if (acc_m) mj++;
            if (rf_we === 1'b1) begin
                is_m = (rf_wd >= 32'h200);
                total++;
                if (is_m ? (qm_data.size() == 0) : (qa_data.size() == 0)) begin
                    bad++; $display("FAIL bp_unexpected_write got=%0d/%0h want=no write", rf_wr, rf_wd);
                end else begin
                    ea = is_m ? qm_addr.pop_front() : qa_addr.pop_front();
                    ed = is_m ? qm_data.pop_front() : qa_data.pop_front();
                    if (rf_wr !== ea || rf_wd !== ed) begin
                        bad++; $display("FAIL bp_write_order got=%0d/%0h want=%0d/%0h", rf_wr, rf_wd, ea, ed);
                    end
                end
                src.push_back(is_m ? 1 : 0);
                if (is_m) last_m = writes;
                writes++;
            end
        end
        a_valid = 1'b0; m_valid = 1'b0;
        for (int i = 1; i <= last_m; i++) if (src[i] == src[i-1]) alt_errs++;
        total++; if (seen_mfull !== 1'b1) begin bad++; $display("FAIL bp_m_ready_drop got=%0b want=1", seen_mfull); end
        total++; if (mj != 3) begin bad++; $display("FAIL bp_m_accepted got=%0d want=3", mj); end
        total++; if (alt_errs != 0) begin bad++; $display("FAIL bp_alternate got=%0d repeats want=0", alt_errs); end
        total++; if (writes != ai + mj) begin bad++; $display("FAIL bp_write_count got=%0d want=%0d", writes, ai + mj); end
        total++; if (qa_data.size() != 0 || qm_data.size() != 0) begin bad++; $display("FAIL bp_lost got=%0d/%0d pending want=0/0", qa_data.size(), qm_data.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%0b want=0", busy); end
    endtask

    task automatic test_reg0();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
        step();
        a_addr = 5'd7; a_data = 32'h1;
        step();
        a_valid = 1'b0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reg0_suppressed got=%0b want=0", rf_we); end
        step();
        total++; if (rf_we !== 1'b1 || rf_wr !== 5'd7 || rf_wd !== 32'h1) begin bad++; $display("FAIL reg0_next got=%0b/%0d/%0h want=1/7/1", rf_we, rf_wr, rf_wd); end
        step();
        total++; if (rf_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reg0_idle we=%0b busy=%0b want=0/0", rf_we, busy); end
    endtask

    task automatic test_async_reset();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h77;
        m_valid = 1'b1; m_addr = 5'd4; m_data = 32'h88;
        step();
        a_valid = 1'b0; m_valid = 1'b0;
        step();
        total++; if (rf_we !== 1'b1 || rf_wd !== 32'h77) begin bad++; $display("FAIL areset_inflight got=%0b/%0h want=1/77", rf_we, rf_wd); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rf_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL areset_drop we=%0b busy=%0b want=0/0", rf_we, busy); end
        step();
        rst_n = 1'b1;
        step();
        step();
        total++; if (rf_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL areset_discard we=%0b busy=%0b want=0/0", rf_we, busy); end
    endtask

`ifdef RF_FWD_EN
    task automatic test_fwd();
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h55;
        step();
        a_valid = 1'b0;
        step();
        rd_addr1 = 5'd9;
        #1;
        total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h55) begin bad++; $display("FAIL fwd_hit got=%0b/%0h want=1/55", fwd_hit1, fwd_data1); end
        rd_addr1 = 5'd0;
        #1;
        total++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0) begin bad++; $display("FAIL fwd_r0 got=%0b/%0h want=0/0", fwd_hit1, fwd_data1); end
        step();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        a_valid = 1'b0; m_valid = 1'b0;
        a_addr = '0; a_data = '0; m_addr = '0; m_data = '0;
`ifdef RF_FWD_EN
        rd_addr1 = '0; rd_addr2 = '0;
`endif
        test_reset();
        test_single_a();
        test_contention();
        test_backpressure();
        test_reg0();
        test_async_reset();
`ifdef RF_FWD_EN
        test_fwd();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
